// File: rtl/cdb_pkg.sv
// Shared constants for the common-data-bus arbiter: unit indices,
// FSM state encoding and width helpers used to size owner/counter fields.
package cdb_pkg;

  // Requester slots on the CDB
  localparam int UNIT_ADD   = 0;
  localparam int UNIT_MUL   = 1;
  localparam int UNIT_LOAD  = 2;
  localparam int UNIT_SPARE = 3;

  // Arbiter FSM encoding
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] GAP   = 2'b10;

  // Width of an index selecting one of n units (at least one bit)
  function automatic int owner_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a down-counter that must hold values up to max_value
  function automatic int count_width(input int max_value);
    return (max_value <= 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotates the request vector so the
// pointer slot sits at bit 0, priority-encodes the lowest set bit, then
// maps the rotated position back to an absolute unit index.
module rr_priority_picker
  import cdb_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int OWNER_W   = owner_width(NUM_UNITS)
) (
  input  logic [NUM_UNITS-1:0] req,
  input  logic [OWNER_W-1:0]   ptr,
  output logic                 valid,
  output logic [OWNER_W-1:0]   winner
);

  localparam logic [OWNER_W:0] NUM_EXT = (OWNER_W + 1)'(NUM_UNITS);

  logic [NUM_UNITS-1:0] rotated;
  logic [OWNER_W-1:0]   offset;
  logic                 found;
  logic [OWNER_W:0]     raw_sum;
  logic [OWNER_W:0]     wrapped_sum;

  // Rotate requests right by the pointer so the search always starts at bit 0
  always_comb begin
    rotated = NUM_UNITS'({req, req} >> ptr);
  end

  // Lowest set bit of the rotated vector is the distance from the pointer
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = OWNER_W'(i);
      end
    end
  end

  // Undo the rotation: winner = (offset + ptr) mod NUM_UNITS
  always_comb begin
    raw_sum     = {1'b0, offset} + {1'b0, ptr};
    wrapped_sum = raw_sum;
    if (raw_sum >= NUM_EXT) begin
      wrapped_sum = raw_sum - NUM_EXT;
    end
    winner = wrapped_sum[OWNER_W-1:0];
    valid  = |req;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one functional unit the bus at a time, holds the
// grant for HOLD_CYCLES so every listener can sample it, then forces a
// turnaround gap (and always at least one idle cycle) before the next grant.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1,
  localparam int OWNER_W    = owner_width(NUM_UNITS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_UNITS-1:0] rts,
  output logic [NUM_UNITS-1:0] xmit,
  output logic                 cdb_busy,
  output logic [OWNER_W-1:0]   cdb_owner,
  output logic                 early_release
);

  localparam int HOLD_W = count_width(HOLD_CYCLES);
  localparam int GAP_W  = count_width(GAP_CYCLES);

  localparam logic [HOLD_W-1:0]  HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [OWNER_W-1:0] LAST_UNIT   = OWNER_W'(NUM_UNITS - 1);
  localparam logic [1:0]         AFTER_GRANT = (GAP_CYCLES == 0) ? IDLE : GAP;

  // Illegal parameter values stop elaboration
  if (NUM_UNITS < 2) begin : g_bad_units
    $error("cdb_arbiter: NUM_UNITS must be at least 2");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("cdb_arbiter: HOLD_CYCLES must be in 1..15");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 7) begin : g_bad_gap
    $error("cdb_arbiter: GAP_CYCLES must be in 0..7");
  end

  logic [1:0]         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [OWNER_W-1:0] ptr;
  logic [OWNER_W-1:0] owner;
  logic               pick_valid;
  logic [OWNER_W-1:0] pick_winner;
  logic               owner_rts;

  rr_priority_picker #(
    .NUM_UNITS (NUM_UNITS),
    .OWNER_W   (OWNER_W)
  ) u_picker (
    .req    (rts),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign owner_rts = rts[owner];

  // FSM, hold/gap counters, round-robin pointer and early-release pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      ptr           <= '0;
      owner         <= '0;
      early_release <= 1'b0;
    end else begin
      early_release <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GRANT;
            owner    <= pick_winner;
            hold_cnt <= HOLD_LOAD;
            ptr      <= (pick_winner == LAST_UNIT) ? '0 : pick_winner + 1'b1;
          end
        end
        GRANT: begin
          if (!owner_rts) begin
            early_release <= 1'b1;
            state         <= AFTER_GRANT;
            gap_cnt       <= GAP_LOAD;
          end else if (hold_cnt == '0) begin
            state   <= AFTER_GRANT;
            gap_cnt <= GAP_LOAD;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Grant is decoded from state so it is one-hot by construction and drops with reset
  always_comb begin
    xmit = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      xmit[i] = (state == GRANT) && (owner == OWNER_W'(i));
    end
  end

  assign cdb_busy  = (state != IDLE);
  assign cdb_owner = owner;

endmodule
